inst_fetch_mem: RTL and testbench

- Parametrised, loadable successor to the fixed instruction ROM.
- A loader writes the program through a write port after reset. The fetch stage then reads instructions through a request/response handshake with one-cycle registered latency and output backpressure.
- Unwritten locations return a default instruction. A halt opcode is detected in the instruction stream, and fetch is frozen until a reload or reset.

---
 rtl/inst_fetch_mem.sv | 158 +++++++++++++++
 tb/tb_inst_fetch_mem.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_mem.sv
// inst_fetch_mem: loadable instruction memory with a request/response fetch
// port. A loader fills the program in LOAD. RUN serves fetches with one
// registered cycle of latency and output backpressure. A halt opcode in the
// fetched stream freezes fetch in HALT until load_start or reset.
module inst_fetch_mem #(
  parameter int              IW           = 10,
  parameter int              AW           = 8,
  parameter int              OPW          = 4,
  parameter logic [OPW-1:0]  HALT_OP      = 4'hF,
  parameter logic [IW-1:0]   DEFAULT_INST = '0
) (
  input  logic          CLK,
  input  logic          Reset_n,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic          load_done,
  input  logic          load_start,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_ready,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [IW-1:0] inst_out,
  output logic [AW-1:0] inst_addr,
  output logic          halt_seen,
  output logic          load_err,
  output logic [AW:0]   prog_len
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  // Storage: contents are never reset; written_q gates what can be read.
  logic [IW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] written_q, written_d;

  state_t           state_q, state_d;
  logic             inst_valid_q, inst_valid_d;
  logic [IW-1:0]    inst_out_q, inst_out_d;
  logic [AW-1:0]    inst_addr_q, inst_addr_d;
  logic             halt_seen_q, halt_seen_d;
  logic             load_err_q, load_err_d;
  logic [AW:0]      prog_len_q, prog_len_d;

  logic             mem_we;
  logic             accept;
  logic [IW-1:0]    rd_word;
  logic             rd_halt;
  logic [AW:0]      load_len;

  // Handshake and read-side decode; single output register means a new
  // request is only taken when the current response leaves this cycle.
  always_comb begin
    mem_we      = (state_q == ST_LOAD) && load_en;
    fetch_ready = (state_q == ST_RUN) && (!inst_valid_q || inst_ready);
    accept      = fetch_req && fetch_ready;
    rd_word     = written_q[fetch_addr] ? mem_q[fetch_addr] : DEFAULT_INST;
    rd_halt     = (rd_word[IW-1 -: OPW] == HALT_OP);
    load_len    = {1'b0, load_addr} + (AW+1)'(1);
  end

  // Next-state logic for the LOAD/RUN/HALT controller and response register.
  always_comb begin
    state_d      = state_q;
    written_d    = written_q;
    inst_valid_d = inst_valid_q;
    inst_out_d   = inst_out_q;
    inst_addr_d  = inst_addr_q;
    halt_seen_d  = halt_seen_q;
    load_err_d   = load_err_q;
    prog_len_d   = prog_len_q;

    case (state_q)
      ST_LOAD: begin
        // A write coinciding with load_done still lands before RUN begins.
        if (load_en) begin
          written_d[load_addr] = 1'b1;
          if (load_len > prog_len_q) begin
            prog_len_d = load_len;
          end
        end
        if (load_done) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN, ST_HALT: begin
        if (load_en) begin
          load_err_d = 1'b1;
        end
        if (load_start) begin
          // Reload keeps written bits and prog_len so it patches in place.
          state_d      = ST_LOAD;
          halt_seen_d  = 1'b0;
          inst_valid_d = 1'b0;
        end else if (accept) begin
          inst_valid_d = 1'b1;
          inst_out_d   = rd_word;
          inst_addr_d  = fetch_addr;
          if (rd_halt) begin
            halt_seen_d = 1'b1;
            state_d     = ST_HALT;
          end
        end else if (inst_ready) begin
          inst_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // Control and response registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_LOAD;
      written_q    <= '0;
      inst_valid_q <= 1'b0;
      inst_out_q   <= '0;
      inst_addr_q  <= '0;
      halt_seen_q  <= 1'b0;
      load_err_q   <= 1'b0;
      prog_len_q   <= '0;
    end else begin
      state_q      <= state_d;
      written_q    <= written_d;
      inst_valid_q <= inst_valid_d;
      inst_out_q   <= inst_out_d;
      inst_addr_q  <= inst_addr_d;
      halt_seen_q  <= halt_seen_d;
      load_err_q   <= load_err_d;
      prog_len_q   <= prog_len_d;
    end
  end

  // Memory array write port; only the loader in LOAD may write.
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign inst_valid = inst_valid_q;
  assign inst_out   = inst_out_q;
  assign inst_addr  = inst_addr_q;
  assign halt_seen  = halt_seen_q;
  assign load_err   = load_err_q;
  assign prog_len   = prog_len_q;

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Testbench for inst_fetch_mem: scoreboard of expected responses pushed on
// each accepted fetch and popped when the consumer takes the response, plus
// per-scenario tasks with inline checks of status outputs.
module tb_inst_fetch_mem;

  localparam int IW = 10;
  localparam int AW = 8;
  localparam logic [IW-1:0] DEF = '0;

  logic          CLK;
  logic          Reset_n;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [IW-1:0] load_data;
  logic          load_done;
  logic          load_start;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_ready;
  logic          inst_valid;
  logic          inst_ready;
  logic [IW-1:0] inst_out;
  logic [AW-1:0] inst_addr;
  logic          halt_seen;
  logic          load_err;
  logic [AW:0]   prog_len;

  int n_vec;
  int n_err;

  logic [IW-1:0]    model_mem [1<<AW];
  bit               model_wr  [1<<AW];
  logic [AW+IW-1:0] sb_q [$];
  logic [AW+IW-1:0] sb_exp;

  inst_fetch_mem dut (
    .CLK        (CLK),
    .Reset_n    (Reset_n),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_done  (load_done),
    .load_start (load_start),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_ready(fetch_ready),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_out   (inst_out),
    .inst_addr  (inst_addr),
    .halt_seen  (halt_seen),
    .load_err   (load_err),
    .prog_len   (prog_len)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  function automatic logic [IW-1:0] model_read(input logic [AW-1:0] a);
    return model_wr[a] ? model_mem[a] : DEF;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < (1 << AW); i++) begin
      model_wr[i]  = 1'b0;
      model_mem[i] = '0;
    end
  endtask

  task automatic load_word(input logic [AW-1:0] a, input logic [IW-1:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
    model_mem[a] = d;
    model_wr[a]  = 1'b1;
  endtask

  task automatic pulse_done();
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic fetch_one(input logic [AW-1:0] a);
    fetch_req  = 1'b1;
    fetch_addr = a;
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    model_clear();
    #12;
    n_vec++;
    if ({inst_valid, halt_seen, load_err, fetch_ready} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got v/h/e/r=%b%b%b%b want 0000", inst_valid, halt_seen, load_err, fetch_ready);
    end
    n_vec++;
    if (inst_out !== '0 || inst_addr !== '0 || prog_len !== '0) begin
      n_err++;
      $display("FAIL reset_data: got out=%h addr=%0d len=%0d want 0/0/0", inst_out, inst_addr, prog_len);
    end
    @(posedge CLK);
    #1;
    Reset_n = 1'b1;
    tick();
  endtask

  task automatic test_load_fetch_halt();
    load_word(8'd0, 10'b0000000001);
    load_word(8'd1, 10'b0001001001);
    load_word(8'd2, 10'b1111111111);
    pulse_done();
    inst_ready = 1'b1;
    fetch_req  = 1'b1;
    for (int a = 0; a < 3; a++) begin
      fetch_addr = AW'(a);
      tick();
    end
    fetch_req = 1'b0;
    #2;
    n_vec++;
    if (halt_seen !== 1'b1) begin
      n_err++;
      $display("FAIL halt_seen_set: got %b want 1", halt_seen);
    end
    n_vec++;
    if (fetch_ready !== 1'b0) begin
      n_err++;
      $display("FAIL halt_blocks_fetch: got fetch_ready=%b want 0", fetch_ready);
    end
    n_vec++;
    if (prog_len !== 9'd3) begin
      n_err++;
      $display("FAIL prog_len_3: got %0d want 3", prog_len);
    end
    tick();
    tick();
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_all: got %0d pending want 0", sb_q.size());
    end
  endtask

  task automatic test_reload_patch();
    pulse_start();
    #2;
    n_vec++;
    if (halt_seen !== 1'b0 || fetch_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reload_clear: got halt=%b ready=%b want 0/0", halt_seen, fetch_ready);
    end
    tick();
    load_word(8'd2, 10'b0011001001);
    pulse_done();
    fetch_one(8'd2);
    #2;
    n_vec++;
    if (inst_out !== 10'h0C9 || halt_seen !== 1'b0) begin
      n_err++;
      $display("FAIL patched_word: got out=%h halt=%b want 0c9/0", inst_out, halt_seen);
    end
    n_vec++;
    if (fetch_ready !== 1'b1) begin
      n_err++;
      $display("FAIL no_halt_ready: got %b want 1", fetch_ready);
    end
    n_vec++;
    if (prog_len !== 9'd3) begin
      n_err++;
      $display("FAIL prog_len_kept: got %0d want 3", prog_len);
    end
    tick();
  endtask

  task automatic test_unwritten();
    fetch_one(8'd200);
    #2;
    n_vec++;
    if (inst_valid !== 1'b1 || inst_addr !== 8'd200 || inst_out !== DEF) begin
      n_err++;
      $display("FAIL unwritten: got v=%b addr=%0d out=%h want 1/200/%h", inst_valid, inst_addr, inst_out, DEF);
    end
    tick();
  endtask

  task automatic test_backpressure();
    inst_ready = 1'b0;
    fetch_one(8'd1);
    fetch_req  = 1'b1;
    fetch_addr = 8'd0;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_vec++;
      if (fetch_ready !== 1'b0 || inst_out !== 10'h049 || inst_addr !== 8'd1) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got ready=%b out=%h addr=%0d want 0/049/1", i, fetch_ready, inst_out, inst_addr);
      end
      @(posedge CLK);
      #1;
    end
    inst_ready = 1'b1;
    #2;
    n_vec++;
    if (fetch_ready !== 1'b1) begin
      n_err++;
      $display("FAIL same_cycle_accept: got %b want 1", fetch_ready);
    end
    @(posedge CLK);
    #1;
    fetch_req = 1'b0;
    #2;
    n_vec++;
    if (inst_valid !== 1'b1 || inst_addr !== 8'd0 || inst_out !== 10'h001) begin
      n_err++;
      $display("FAIL after_stall: got v=%b addr=%0d out=%h want 1/0/001", inst_valid, inst_addr, inst_out);
    end
    tick();
  endtask

  task automatic test_load_err_reset();
    load_en   = 1'b1;
    load_addr = 8'd0;
    load_data = 10'h155;
    tick();
    load_en = 1'b0;
    #2;
    n_vec++;
    if (load_err !== 1'b1) begin
      n_err++;
      $display("FAIL load_err_set: got %b want 1", load_err);
    end
    tick();
    fetch_one(8'd0);
    #2;
    n_vec++;
    if (inst_out !== 10'h001) begin
      n_err++;
      $display("FAIL no_write_in_run: got %h want 001", inst_out);
    end
    tick();
    inst_ready = 1'b0;
    fetch_one(8'd1);
    Reset_n = 1'b0;
    model_clear();
    #1;
    n_vec++;
    if (inst_valid !== 1'b0 || inst_out !== '0 || inst_addr !== '0) begin
      n_err++;
      $display("FAIL async_reset_resp: got v=%b out=%h addr=%0d want 0/0/0", inst_valid, inst_out, inst_addr);
    end
    n_vec++;
    if (load_err !== 1'b0 || prog_len !== '0 || halt_seen !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_stat: got err=%b len=%0d halt=%b want 0/0/0", load_err, prog_len, halt_seen);
    end
    tick();
    Reset_n = 1'b1;
    tick();
    pulse_done();
    inst_ready = 1'b1;
    fetch_one(8'd0);
    #2;
    n_vec++;
    if (inst_valid !== 1'b1 || inst_out !== DEF) begin
      n_err++;
      $display("FAIL fetch_after_reset: got v=%b out=%h want 1/%h", inst_valid, inst_out, DEF);
    end
    tick();
  endtask

  task automatic test_load_and_done();
    pulse_start();
    load_en   = 1'b1;
    load_done = 1'b1;
    load_addr = 8'd5;
    load_data = 10'h2AA;
    tick();
    load_en   = 1'b0;
    load_done = 1'b0;
    model_mem[5] = 10'h2AA;
    model_wr[5]  = 1'b1;
    #2;
    n_vec++;
    if (fetch_ready !== 1'b1) begin
      n_err++;
      $display("FAIL run_after_done: got fetch_ready=%b want 1", fetch_ready);
    end
    n_vec++;
    if (prog_len !== 9'd6) begin
      n_err++;
      $display("FAIL prog_len_6: got %0d want 6", prog_len);
    end
    tick();
    fetch_one(8'd5);
    #2;
    n_vec++;
    if (inst_out !== 10'h2AA || inst_addr !== 8'd5) begin
      n_err++;
      $display("FAIL load_done_word: got out=%h addr=%0d want 2aa/5", inst_out, inst_addr);
    end
    tick();
    tick();
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    Reset_n    = 1'b0;
    load_en    = 1'b0;
    load_addr  = '0;
    load_data  = '0;
    load_done  = 1'b0;
    load_start = 1'b0;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    inst_ready = 1'b1;

    fork
      // Scoreboard monitor: compare the presented response, pop on consume,
      // push the model's word for every accepted request.
      forever begin
        @(negedge CLK);
        if (!Reset_n) begin
          sb_q.delete();
        end else begin
          n_vec++;
          if (inst_valid !== (sb_q.size() != 0)) begin
            n_err++;
            $display("FAIL sb_valid: got inst_valid=%b want %b", inst_valid, sb_q.size() != 0);
          end
          if (inst_valid === 1'b1 && sb_q.size() != 0) begin
            sb_exp = sb_q[0];
            n_vec++;
            if ({inst_addr, inst_out} !== sb_exp) begin
              n_err++;
              $display("FAIL sb_resp: got addr=%0d out=%h want addr=%0d out=%h", inst_addr, inst_out, sb_exp[AW+IW-1:IW], sb_exp[IW-1:0]);
            end
            if (inst_ready) begin
              void'(sb_q.pop_front());
            end
          end
          if (load_start) begin
            sb_q.delete();
          end else if (fetch_req && fetch_ready === 1'b1) begin
            sb_q.push_back({fetch_addr, model_read(fetch_addr)});
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    test_reset();
    test_load_fetch_halt();
    test_reload_patch();
    test_unwritten();
    test_backpressure();
    test_load_err_reset();
    test_load_and_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
